sram_result_writer: RTL and testbench

- Write-side counterpart of the compute block's input-SRAM read path.
- Accepts a stream of result elements from the compute core and packs 2/4/8/16-bit elements into 16-bit words.
- Writes the packed words to output SRAM, followed by a two-word header (element count, element size) in the same layout the compute block reads back.
- Sits between the core datapath and the output SRAM write port (dut_sram_write_*).

---
 rtl/sram_result_writer_if.sv | 35 +++
 rtl/sram_result_writer.sv | 167 ++++++++++++++++
 tb/tb_sram_result_writer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_result_writer_if.sv
// Bundles the run control, result stream and SRAM write port of sram_result_writer.
// The slave modport is the writer; the master modport is the core/test side.
interface sram_result_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic [4:0]        elem_size;
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              result_last;
  logic              result_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;
  logic [2:0]        dbg_state;

  // Handshake: an element transfers on any posedge where result_valid && result_ready;
  // result_data/result_last are only meaningful while result_valid is high.
  modport slave (
    input  start, elem_size, result_valid, result_data, result_last,
    output result_ready, busy, done,
    output dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable,
    output dbg_state
  );

  modport master (
    output start, elem_size, result_valid, result_data, result_last,
    input  result_ready, busy, done,
    input  dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable,
    input  dbg_state
  );
endinterface

// File: rtl/sram_result_writer.sv
// Packs 2/4/8/16-bit result elements LSB-first into 16-bit SRAM words, then writes
// the count/size header. Optional WRITER_CHECKSUM_EN appends an XOR of the data words.
module sram_result_writer #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DATA_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  sram_result_writer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_HDR_COUNT,
    S_HDR_SIZE,
`ifdef WRITER_CHECKSUM_EN
    S_CHECKSUM,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [4:0]        size_q;
  logic [DATA_W-1:0] pack_q;
  logic [2:0]        slot_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
`ifdef WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  logic [4:0]        size_d;
  logic [2:0]        last_slot;
  logic [DATA_W-1:0] elem_mask;
  logic [6:0]        shamt;
  logic [DATA_W-1:0] pack_d;
  logic              hs;
  logic              word_end;

  // Unsupported widths collapse to 16 so the header always reports what was packed.
  always_comb begin
    size_d = 5'd16;
    if (bus.elem_size == 5'd2 || bus.elem_size == 5'd4 || bus.elem_size == 5'd8)
      size_d = bus.elem_size;
  end

  always_comb begin
    last_slot = 3'd0;
    elem_mask = {DATA_W{1'b1}};
    case (size_q)
      5'd2:    begin last_slot = 3'd7; elem_mask = 16'h0003; end
      5'd4:    begin last_slot = 3'd3; elem_mask = 16'h000F; end
      5'd8:    begin last_slot = 3'd1; elem_mask = 16'h00FF; end
      default: begin last_slot = 3'd0; elem_mask = {DATA_W{1'b1}}; end
    endcase
  end

  assign shamt    = {4'b0, slot_q} * {2'b0, size_q};
  assign pack_d   = pack_q | ((bus.result_data & elem_mask) << shamt);
  assign hs       = bus.result_valid && (state_q == S_DATA);
  assign word_end = hs && ((slot_q == last_slot) || bus.result_last);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      size_q      <= 5'd0;
      pack_q      <= '0;
      slot_q      <= 3'd0;
      count_q     <= 16'd0;
      data_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef WRITER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            size_q      <= size_d;
            data_addr_q <= BASE_ADDR + ADDR_W'(2);
            count_q     <= 16'd0;
            slot_q      <= 3'd0;
            pack_q      <= '0;
`ifdef WRITER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            busy_q      <= 1'b1;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (hs) begin
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            // A last element that also fills the word still yields a single write.
            if (word_end) begin
              wr_en_q     <= 1'b1;
              wr_addr_q   <= data_addr_q;
              wr_data_q   <= pack_d;
              data_addr_q <= data_addr_q + ADDR_W'(1);
              slot_q      <= 3'd0;
              pack_q      <= '0;
`ifdef WRITER_CHECKSUM_EN
              csum_q      <= csum_q ^ pack_d;
`endif
            end else begin
              pack_q <= pack_d;
              slot_q <= slot_q + 3'd1;
            end
            if (bus.result_last) state_q <= S_HDR_COUNT;
          end
        end
        S_HDR_COUNT: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= BASE_ADDR;
          wr_data_q <= count_q;
          state_q   <= S_HDR_SIZE;
        end
        S_HDR_SIZE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= BASE_ADDR + ADDR_W'(1);
          wr_data_q <= {{(DATA_W-5){1'b0}}, size_q};
`ifdef WRITER_CHECKSUM_EN
          state_q   <= S_CHECKSUM;
`else
          state_q   <= S_DONE;
`endif
        end
`ifdef WRITER_CHECKSUM_EN
        S_CHECKSUM: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= data_addr_q;
          wr_data_q <= csum_q;
          state_q   <= S_DONE;
        end
`endif
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result_ready           = (state_q == S_DATA);
  assign bus.busy                   = busy_q;
  assign bus.done                   = done_q;
  assign bus.dut_sram_write_enable  = wr_en_q;
  assign bus.dut_sram_write_address = wr_addr_q;
  assign bus.dut_sram_write_data    = wr_data_q;
  assign bus.dbg_state              = state_q;

endmodule

// File: tb/tb_sram_result_writer.sv
// Directed and randomised runs of sram_result_writer; every SRAM write is matched
// in order against a queue of {address, data} pairs built from a packing model.
module tb_sram_result_writer;

  localparam logic [11:0] BASE = 12'h000;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  sram_result_writer_if bus ();

  sram_result_writer #(.ADDR_W(12), .BASE_ADDR(BASE), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [27:0] exp_q[$];
  logic [15:0] stim[64];
  logic [27:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dut_sram_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
               bus.dut_sram_write_address, bus.dut_sram_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sram_write", {4'b0, bus.dut_sram_write_address, bus.dut_sram_write_data},
              {4'b0, mon_e});
      end
    end
  end

  task automatic do_start(input logic [4:0] s);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.elem_size = s;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.elem_size = 5'(($urandom_range(0, 31)));
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    check("ready", {31'b0, bus.result_ready}, 32'd1);
    bus.result_valid = 1'b1;
    bus.result_data  = d;
    bus.result_last  = last;
    @(posedge clk);
    #1 bus.result_valid = 1'b0;
    bus.result_last  = 1'b0;
    bus.result_data  = 16'($urandom);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'b0, got}, 32'd1);
    check("busy_at_done", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'b0, bus.done}, 32'd0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  // Model: pack stim[0..n-1], queue data, header and optional checksum writes, then drive.
  task automatic run(input logic [4:0] s_raw, input int n, input int mid_start);
    int          s;
    int          epw;
    int          slot;
    logic [15:0] word;
    logic [15:0] mask;
    logic [15:0] x;
    logic [11:0] addr;
    s    = (s_raw == 5'd2 || s_raw == 5'd4 || s_raw == 5'd8) ? int'(s_raw) : 16;
    epw  = 16 / s;
    mask = (s == 16) ? 16'hFFFF : 16'((1 << s) - 1);
    word = 16'h0;
    slot = 0;
    x    = 16'h0;
    addr = BASE + 12'd2;
    for (int i = 0; i < n; i++) begin
      word = word | ((stim[i] & mask) << (slot * s));
      slot++;
      if (slot == epw || i == n - 1) begin
        exp_q.push_back({addr, word});
        x    = x ^ word;
        addr = addr + 12'd1;
        word = 16'h0;
        slot = 0;
      end
    end
    exp_q.push_back({BASE, 16'(n)});
    exp_q.push_back({BASE + 12'd1, 16'(s)});
`ifdef WRITER_CHECKSUM_EN
    exp_q.push_back({addr, x});
`endif
    do_start(s_raw);
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == mid_start) begin
        bus.start     = 1'b1;
        bus.elem_size = 5'd2;
      end
      send(stim[i], (i == n - 1));
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.elem_size    = 5'd0;
    bus.result_valid = 1'b0;
    bus.result_data  = 16'h0;
    bus.result_last  = 1'b0;

    // Reset held with inputs toggling: nothing may come out.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 bus.start = ~bus.start;
      bus.result_valid = ~bus.result_valid;
      bus.result_last  = ~bus.result_last;
      bus.elem_size    = 5'd8;
      @(negedge clk);
      check("rst_we",    {31'b0, bus.dut_sram_write_enable}, 32'd0);
      check("rst_busy",  {31'b0, bus.busy}, 32'd0);
      check("rst_done",  {31'b0, bus.done}, 32'd0);
      check("rst_ready", {31'b0, bus.result_ready}, 32'd0);
    end
    check("rst_addr", {20'b0, bus.dut_sram_write_address}, 32'd0);
    check("rst_data", {16'b0, bus.dut_sram_write_data}, 32'd0);
    bus.start        = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_last  = 1'b0;
    @(posedge clk);
    #1 reset_b = 1'b1;

    // S=8, three elements: one full word plus a zero-padded partial word.
    stim[0] = 16'h0011; stim[1] = 16'h0022; stim[2] = 16'h0033;
    run(5'd8, 3, -1);

    // S=2, eight elements of 3: a single full word.
    for (int i = 0; i < 8; i++) stim[i] = 16'h0003;
    run(5'd2, 8, -1);

    // S=4, last element fills the word; start pulsed mid-run.
    stim[0] = 16'h1; stim[1] = 16'h2; stim[2] = 16'h3; stim[3] = 16'h4;
    run(5'd4, 4, 2);

    // S=4 with junk above the element width.
    stim[0] = 16'hFFF5;
    run(5'd4, 1, -1);

    // Unsupported width behaves as 16.
    stim[0] = 16'hBEEF;
    run(5'd5, 1, -1);

    // S=16 aborted by reset after two elements.
    exp_q.push_back({BASE + 12'd2, 16'hAAAA});
    exp_q.push_back({BASE + 12'd3, 16'hBBBB});
    do_start(5'd16);
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    @(negedge clk);
    #1 reset_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_we",   {31'b0, bus.dut_sram_write_enable}, 32'd0);
    end
    @(posedge clk);
    #1 reset_b = 1'b1;
    check("abort_queue", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", {31'b0, bus.busy}, 32'd0);
    stim[0] = 16'h1234;
    run(5'd16, 1, -1);

    // Two-word S=16 run (checksum 0x0FF0 at address 4 when enabled).
    stim[0] = 16'h00F0; stim[1] = 16'h0F00;
    run(5'd16, 2, -1);

    // Randomised runs.
    for (int r = 0; r < 6; r++) begin
      logic [4:0] s;
      int         n;
      case ($urandom_range(0, 3))
        0:       s = 5'd2;
        1:       s = 5'd4;
        2:       s = 5'd8;
        default: s = 5'd16;
      endcase
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) stim[i] = 16'($urandom);
      run(s, n, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
